// File: rtl/rvb_shifter_pipe.sv
// Pipelined bitmanip shift/rotate/funnel/single-bit unit with valid/ready handshake.
// Optional single-bit ops (SBSET/SBCLR/SBINV/SBEXT) enabled by RVB_SHIFTER_PIPE_SBOP_EN.
module rvb_shifter_pipe #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAGW   = 4
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [XLEN-1:0] din_rs1,
    input  logic [XLEN-1:0] din_rs2,
    input  logic [XLEN-1:0] din_rs3,
    input  logic            din_insn3,
    input  logic            din_insn14,
    input  logic            din_insn26,
    input  logic            din_insn27,
    input  logic            din_insn29,
    input  logic            din_insn30,
    input  logic [TAGW-1:0] din_tag,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [XLEN-1:0] dout_rd,
    output logic [TAGW-1:0] dout_tag
);
    localparam int unsigned LW = $clog2(XLEN);
    localparam int unsigned AW = LW + 1;
    localparam int unsigned PW = XLEN + 15;
    localparam int unsigned VW = 2 * XLEN;

    typedef enum logic [3:0] {
        OP_NONE, OP_SLL, OP_SRL, OP_SRA, OP_SLO, OP_SRO, OP_ROL, OP_ROR,
        OP_FSL, OP_FSR, OP_SBSET, OP_SBCLR, OP_SBINV, OP_SBEXT
    } op_e;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        op_e             op;
        logic            w;
        logic [3:0]      fine;
        logic [PW-1:0]   part;
`ifdef RVB_SHIFTER_PIPE_SBOP_EN
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] a;
`endif
    } s1_t;

    op_e             op;
    logic            w;
    logic            sign;
    logic            swap;
    logic [AW-1:0]   n_val;
    logic [AW-1:0]   s_amt;
    logic [AW-1:0]   f_amt;
    logic [AW-1:0]   f_s;
    logic [AW-1:0]   amt;
    logic [XLEN-1:0] a_n;
    logic [XLEN-1:0] b_n;
    logic [XLEN-1:0] fa;
    logic [XLEN-1:0] fb;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [VW-1:0]   v;
    logic [PW-1:0]   part;
    s1_t             s1_d;
    s1_t             s1_cur;
    logic            s1_valid;
    logic            s1_load;
    logic            out_load;
    logic            accept;
    logic            run_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_rd_q;
    logic [TAGW-1:0] out_tag_q;
    logic [XLEN-1:0] shr;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] res_w;
    logic            rs2_unused;

    assign rs2_unused = ^din_rs2[XLEN-1:AW];

    // Opcode decode from instruction bits {30,29,27,26,14}
    always_comb begin
        op = OP_NONE;
        casez ({din_insn30, din_insn29, din_insn27, din_insn26, din_insn14})
            5'b00000: op = OP_SLL;
            5'b00001: op = OP_SRL;
            5'b10001: op = OP_SRA;
            5'b01000: op = OP_SLO;
            5'b01001: op = OP_SRO;
            5'b11000: op = OP_ROL;
            5'b11001: op = OP_ROR;
            5'b???10: op = OP_FSL;
            5'b???11: op = OP_FSR;
`ifdef RVB_SHIFTER_PIPE_SBOP_EN
            5'b01100: op = OP_SBSET;
            5'b10100: op = OP_SBCLR;
            5'b11100: op = OP_SBINV;
            5'b10101: op = OP_SBEXT;
`endif
            default:  op = OP_NONE;
        endcase
    end

    // Every shift is mapped onto a right funnel of {hi,lo} by amt in 0..N
    always_comb begin
        w     = (XLEN == 32) || din_insn3;
        n_val = w ? AW'(32) : AW'(XLEN);
        s_amt = w ? AW'(din_rs2[4:0]) : AW'(din_rs2[LW-1:0]);
        f_amt = w ? AW'(din_rs2[5:0]) : AW'(din_rs2[LW:0]);
        a_n   = w ? XLEN'(din_rs1[31:0]) : din_rs1;
        b_n   = w ? XLEN'(din_rs3[31:0]) : din_rs3;
        sign  = w ? din_rs1[31] : din_rs1[XLEN-1];
        swap  = (f_amt >= n_val);
        fa    = swap ? b_n : a_n;
        fb    = swap ? a_n : b_n;
        f_s   = swap ? (f_amt - n_val) : f_amt;
        hi    = '0;
        lo    = '0;
        amt   = s_amt;
        case (op)
            OP_SLL: begin hi = a_n;          lo = '0;  amt = n_val - s_amt; end
            OP_SRL: begin hi = '0;           lo = a_n; amt = s_amt;         end
            OP_SRA: begin hi = {XLEN{sign}}; lo = a_n; amt = s_amt;         end
            OP_SLO: begin hi = a_n;          lo = '1;  amt = n_val - s_amt; end
            OP_SRO: begin hi = '1;           lo = a_n; amt = s_amt;         end
            OP_ROL: begin hi = a_n;          lo = a_n; amt = n_val - s_amt; end
            OP_ROR: begin hi = a_n;          lo = a_n; amt = s_amt;         end
            OP_FSL: begin hi = fa;           lo = fb;  amt = n_val - f_s;   end
            OP_FSR: begin hi = fb;           lo = fa;  amt = f_s;           end
            default: ;
        endcase
        v    = w ? VW'({hi[31:0], lo[31:0]}) : {hi, lo};
        part = PW'(v >> {amt[AW-1:4], 4'b0000});
    end

    always_comb begin
        s1_d      = '0;
        s1_d.tag  = din_tag;
        s1_d.op   = op;
        s1_d.w    = w;
        s1_d.fine = amt[3:0];
        s1_d.part = part;
`ifdef RVB_SHIFTER_PIPE_SBOP_EN
        s1_d.idx  = s_amt;
        s1_d.a    = a_n;
`endif
    end

    assign out_load  = !out_valid_q || dout_ready;
    assign din_ready = run_q && s1_load;
    assign accept    = din_valid && din_ready;

    generate
        if (STAGES == 2) begin : g_two
            logic s1_valid_q;
            s1_t  s1_q;

            assign s1_load  = !s1_valid_q || out_load;
            assign s1_valid = s1_valid_q;
            assign s1_cur   = s1_q;

            // Stage 1: decoded op and coarse-shifted partial
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    s1_valid_q <= 1'b0;
                    s1_q       <= '0;
                end else if (s1_load) begin
                    s1_valid_q <= accept;
                    if (accept) begin
                        s1_q <= s1_d;
                    end
                end
            end
        end else begin : g_one
            assign s1_load  = out_load;
            assign s1_valid = accept;
            assign s1_cur   = s1_d;
        end
    endgenerate

    // Fine shift, bit-op post-processing and word-mode sign extension
    always_comb begin
        shr = XLEN'(s1_cur.part >> s1_cur.fine);
        res = shr;
        case (s1_cur.op)
            OP_NONE:  res = '0;
`ifdef RVB_SHIFTER_PIPE_SBOP_EN
            OP_SBSET: res = s1_cur.a | (XLEN'(1) << s1_cur.idx);
            OP_SBCLR: res = s1_cur.a & ~(XLEN'(1) << s1_cur.idx);
            OP_SBINV: res = s1_cur.a ^ (XLEN'(1) << s1_cur.idx);
            OP_SBEXT: res = (s1_cur.a >> s1_cur.idx) & XLEN'(1);
`endif
            default: ;
        endcase
        res_w = s1_cur.w ? XLEN'($signed(res[31:0])) : res;
    end

    // din_ready held low through reset and rises one cycle after release
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_tag_q   <= '0;
        end else if (out_load) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_rd_q  <= res_w;
                out_tag_q <= s1_cur.tag;
            end
        end
    end

    assign dout_valid = out_valid_q;
    assign dout_rd    = out_rd_q;
    assign dout_tag   = out_tag_q;

endmodule

// File: tb/tb_rvb_shifter_pipe.sv
// Directed self-checking bench for rvb_shifter_pipe (XLEN=64, STAGES=2, TAGW=4).
module tb_rvb_shifter_pipe;
    logic        clock;
    logic        resetn;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] din_rs1;
    logic [63:0] din_rs2;
    logic [63:0] din_rs3;
    logic        din_insn3, din_insn14, din_insn26, din_insn27, din_insn29, din_insn30;
    logic [3:0]  din_tag;
    logic        dout_valid;
    logic        dout_ready;
    logic [63:0] dout_rd;
    logic [3:0]  dout_tag;

    int          checks;
    int          failures;
    logic [3:0]  tag_ctr;

    rvb_shifter_pipe #(.XLEN(64), .STAGES(2), .TAGW(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_rs1    (din_rs1),
        .din_rs2    (din_rs2),
        .din_rs3    (din_rs3),
        .din_insn3  (din_insn3),
        .din_insn14 (din_insn14),
        .din_insn26 (din_insn26),
        .din_insn27 (din_insn27),
        .din_insn29 (din_insn29),
        .din_insn30 (din_insn30),
        .din_tag    (din_tag),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_rd    (dout_rd),
        .dout_tag   (dout_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%016h expected=0x%016h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] code, input logic w3, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [63:0] rs3, input logic [3:0] t);
        {din_insn30, din_insn29, din_insn27, din_insn26, din_insn14} = code;
        din_insn3 = w3;
        din_rs1   = rs1;
        din_rs2   = rs2;
        din_rs3   = rs3;
        din_tag   = t;
        din_valid = 1'b1;
    endtask

    // One op through an idle pipe: accepted immediately, result exactly two cycles later
    task automatic run_op(input string name, input logic [4:0] code, input logic w3,
                          input logic [63:0] rs1, input logic [63:0] rs2,
                          input logic [63:0] rs3, input logic [63:0] exp);
        logic [3:0] t;
        t       = tag_ctr;
        tag_ctr = tag_ctr + 4'd1;
        @(negedge clock);
        dout_ready = 1'b1;
        drive(code, w3, rs1, rs2, rs3, t);
        #1;
        check({name, " din_ready"}, 64'(din_ready), 64'd1);
        @(negedge clock);
        din_valid = 1'b0;
        check({name, " lat1 valid"}, 64'(dout_valid), 64'd0);
        @(negedge clock);
        check({name, " valid"}, 64'(dout_valid), 64'd1);
        check({name, " rd"}, dout_rd, exp);
        check({name, " tag"}, 64'(dout_tag), 64'(t));
    endtask

    initial begin
        int         next_send;
        int         next_exp;
        int         done_cyc;
        logic       held;
        logic [3:0] held_tag;
        logic [63:0] held_rd;
        logic [63:0] exp_sbext, exp_sbinv, exp_sbset, exp_sbclr;

        checks     = 0;
        failures   = 0;
        tag_ctr    = 4'd1;
        resetn     = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        drive(5'b00000, 1'b0, 64'd0, 64'd0, 64'd0, 4'd0);
        din_valid  = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst dout_valid", 64'(dout_valid), 64'd0);
        check("rst dout_rd", dout_rd, 64'd0);
        check("rst dout_tag", 64'(dout_tag), 64'd0);
        check("rst din_ready", 64'(din_ready), 64'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("post-rst din_ready", 64'(din_ready), 64'd1);

        // Directed ops
        run_op("SLL 63",      5'b00000, 1'b0, 64'h1, 64'd63, 64'h0, 64'h8000_0000_0000_0000);
        run_op("SLL 64",      5'b00000, 1'b0, 64'h1234, 64'd64, 64'h0, 64'h1234);
        run_op("SRAW",        5'b10001, 1'b1, 64'h8000_0000, 64'd4, 64'h0, 64'hFFFF_FFFF_F800_0000);
        run_op("SRA 63",      5'b10001, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("SRLW",        5'b00001, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd36, 64'h0, 64'h0000_0000_0800_0000);
        run_op("ROR",         5'b11001, 1'b0, 64'h1, 64'd1, 64'h0, 64'h8000_0000_0000_0000);
        run_op("ROL",         5'b11000, 1'b0, 64'h8000_0000_0000_0001, 64'd4, 64'h0, 64'h18);
        run_op("SLO",         5'b01000, 1'b0, 64'h0, 64'd4, 64'h0, 64'hF);
        run_op("SRO",         5'b01001, 1'b0, 64'h0, 64'd60, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0);
        run_op("FSR swap",    5'b00011, 1'b0, 64'h1, 64'd64, 64'hAA, 64'hAA);
        run_op("FSL",         5'b00010, 1'b0, 64'h1, 64'd1, 64'h8000_0000_0000_0000, 64'h3);
        run_op("FSR",         5'b00011, 1'b0, 64'hF0, 64'd4, 64'h1, 64'h1000_0000_0000_000F);
        run_op("unlisted",    5'b00100, 1'b0, 64'hFFFF, 64'd3, 64'h0, 64'h0);

`ifdef RVB_SHIFTER_PIPE_SBOP_EN
        exp_sbext = 64'h1;
        exp_sbinv = 64'h2;
        exp_sbset = 64'h8;
        exp_sbclr = 64'hFE;
`else
        exp_sbext = 64'h0;
        exp_sbinv = 64'h0;
        exp_sbset = 64'h0;
        exp_sbclr = 64'h0;
`endif
        run_op("SBEXT",       5'b10101, 1'b0, 64'h10, 64'd4, 64'h0, exp_sbext);
        run_op("SBINV",       5'b11100, 1'b0, 64'h0, 64'd65, 64'h0, exp_sbinv);
        run_op("SBSET",       5'b01100, 1'b0, 64'h0, 64'd3, 64'h0, exp_sbset);
        run_op("SBCLR",       5'b10100, 1'b0, 64'hFF, 64'd0, 64'h0, exp_sbclr);

        // Stream of 6 tagged ops with dout_ready low for cycles 3..5
        @(negedge clock);
        din_valid = 1'b0;
        next_send = 0;
        next_exp  = 0;
        done_cyc  = -1;
        held      = 1'b0;
        held_tag  = 4'd0;
        held_rd   = 64'd0;
        for (int cyc = 0; cyc < 40 && next_exp < 6; cyc++) begin
            if (cyc > 0) @(negedge clock);
            dout_ready = !(cyc >= 3 && cyc <= 5);
            if (next_send < 6) begin
                drive(5'b00000, 1'b0, 64'(next_send + 1), 64'(next_send), 64'h0, 4'(next_send));
            end else begin
                din_valid = 1'b0;
            end
            #1;
            if (cyc == 4) check("stream din_ready full", 64'(din_ready), 64'd0);
            if (cyc == 6) check("stream din_ready resume", 64'(din_ready), 64'd1);
            if (held) begin
                check("stream hold valid", 64'(dout_valid), 64'd1);
                check("stream hold tag", 64'(dout_tag), 64'(held_tag));
                check("stream hold rd", dout_rd, held_rd);
            end
            if (dout_valid && dout_ready) begin
                check("stream tag order", 64'(dout_tag), 64'(next_exp));
                check("stream rd", dout_rd, 64'(next_exp + 1) << next_exp);
                next_exp++;
                if (next_exp == 6) done_cyc = cyc;
            end
            held     = dout_valid && !dout_ready;
            held_tag = dout_tag;
            held_rd  = dout_rd;
            if (din_valid && din_ready) next_send++;
        end
        check("stream retired count", 64'(next_exp), 64'd6);
        check("stream last retire cycle", 64'(done_cyc), 64'd10);

        // Reset with two ops in flight
        @(negedge clock);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(negedge clock);
        drive(5'b00000, 1'b0, 64'h7, 64'd0, 64'h0, 4'd7);
        @(negedge clock);
        drive(5'b00000, 1'b0, 64'h8, 64'd0, 64'h0, 4'd8);
        @(negedge clock);
        din_valid = 1'b0;
        check("inflight valid", 64'(dout_valid), 64'd1);
        check("inflight tag", 64'(dout_tag), 64'd7);
        #1 resetn = 1'b0;
        #1;
        check("midrst dout_valid", 64'(dout_valid), 64'd0);
        check("midrst dout_rd", dout_rd, 64'd0);
        check("midrst dout_tag", 64'(dout_tag), 64'd0);
        check("midrst din_ready", 64'(din_ready), 64'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("no stale op", 64'(dout_valid), 64'd0);
        end
        run_op("post-rst SLL", 5'b00000, 1'b0, 64'h3, 64'd2, 64'h0, 64'hC);

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
